// File: rtl/skeleton_capture_pkg.sv
// Shared types and constants for the skeleton run controller.
package skeleton_capture_pkg;

  localparam int PERIOD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    RUN     = 2'd2,
    READOUT = 2'd3
  } state_e;

endpackage

// File: rtl/skeleton_capture_ctrl_buffer.sv
// Simple dual-port capture RAM: one synchronous write port, one registered read port.
module capture_buffer #(
  parameter  int DEPTH  = 64,
  parameter  int WIDTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/skeleton_capture_ctrl.sv
// Skeleton run controller: triggers the skeleton, captures result words into a
// buffer until end-of-sequence or full, then streams them out over valid/ready.
module skeleton_capture_ctrl
  import skeleton_capture_pkg::*;
#(
  parameter  int BITWIDTH_SYS  = 16,
  parameter  int BITWIDTH_HEAD = 26,
  parameter  int DEPTH         = 64,
  parameter  int CAPT_LAT      = 1,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic                     CLK_SYS,
  input  logic                     RSTN,
  input  logic                     START,
  input  logic [PERIOD_W-1:0]      CFG_PERIOD,
  input  logic [BITWIDTH_SYS-1:0]  CFG_DATA,
  output logic                     DUT_EN,
  output logic                     DUT_TRGG,
  output logic [BITWIDTH_SYS-1:0]  DUT_DATA_IN,
  input  logic [BITWIDTH_SYS-1:0]  DUT_DATA_OUT,
  input  logic [BITWIDTH_HEAD-1:0] DUT_HEAD,
  input  logic                     DUT_RDY,
  output logic                     RD_VALID,
  input  logic                     RD_READY,
  output logic [BITWIDTH_SYS-1:0]  RD_DATA,
  output logic                     RD_LAST,
  output logic [BITWIDTH_HEAD-1:0] HEAD_OUT,
  output logic                     BUSY,
  output logic                     OVERFLOW,
  output logic [ADDR_W:0]          SAMPLE_CNT
);

  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

  state_e                   state_q, state_d;
  logic [PERIOD_W-1:0]      period_q, period_d;
  logic [PERIOD_W-1:0]      cnt_q, cnt_d;
  logic [BITWIDTH_SYS-1:0]  data_q, data_d;
  logic [BITWIDTH_HEAD-1:0] head_q, head_d;
  logic [CAPT_LAT-1:0]      lat_q, lat_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]          sample_cnt_q, sample_cnt_d;
  logic                     overflow_q, overflow_d;
  logic                     bypass_q, bypass_d;
  logic [BITWIDTH_SYS-1:0]  bypass_data_q, bypass_data_d;

  logic                     trig;
  logic                     capture;
  logic                     stop;
  logic                     handshake;
  logic                     rd_last;
  logic [ADDR_W-1:0]        rd_addr;
  logic [BITWIDTH_SYS-1:0]  ram_rd_data;

  assign trig      = (state_q == RUN) && (cnt_q == '0);
  assign capture   = (state_q == RUN) && lat_q[CAPT_LAT-1];
  assign stop      = capture && (DUT_RDY || (sample_cnt_q == LAST_SLOT));
  assign handshake = (state_q == READOUT) && RD_READY;
  assign rd_last   = ({1'b0, rd_ptr_q} == (sample_cnt_q - 1'b1));
  // Prefetch: on a handshake fetch the next word so it appears without a bubble.
  assign rd_addr   = handshake ? rd_ptr_q + 1'b1 : rd_ptr_q;

  capture_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (BITWIDTH_SYS)
  ) u_buffer (
    .clk_i     (CLK_SYS),
    .wr_en_i   (capture),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (DUT_DATA_OUT),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rd_data)
  );

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = ARM;
      ARM:     state_d = RUN;
      RUN:     if (stop) state_d = READOUT;
      READOUT: if (handshake && rd_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    DUT_EN      = 1'b0;
    DUT_TRGG    = 1'b0;
    DUT_DATA_IN = '0;
    RD_VALID    = 1'b0;
    RD_LAST     = 1'b0;
    RD_DATA     = '0;
    BUSY        = (state_q != IDLE);
    unique case (state_q)
      RUN: begin
        DUT_EN      = 1'b1;
        DUT_TRGG    = trig;
        DUT_DATA_IN = data_q;
      end
      READOUT: begin
        RD_VALID = 1'b1;
        RD_LAST  = rd_last;
        RD_DATA  = bypass_q ? bypass_data_q : ram_rd_data;
      end
      default: ;
    endcase
  end

  assign HEAD_OUT   = head_q;
  assign OVERFLOW   = overflow_q;
  assign SAMPLE_CNT = sample_cnt_q;

  always_comb begin
    period_d      = period_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    head_d        = head_q;
    lat_d         = lat_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    sample_cnt_d  = sample_cnt_q;
    overflow_d    = overflow_q;
    // A read that collides with the same-cycle write would return stale RAM data.
    bypass_d      = capture && (wr_ptr_q == rd_addr);
    bypass_data_d = DUT_DATA_OUT;
    unique case (state_q)
      ARM: begin
        period_d     = (CFG_PERIOD == '0) ? PERIOD_W'(1) : CFG_PERIOD;
        data_d       = CFG_DATA;
        head_d       = DUT_HEAD;
        cnt_d        = '0;
        lat_d        = '0;
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
        sample_cnt_d = '0;
        overflow_d   = 1'b0;
      end
      RUN: begin
        cnt_d    = trig ? period_q - 1'b1 : cnt_q - 1'b1;
        lat_d[0] = trig;
        for (int i = 1; i < CAPT_LAT; i++) begin
          lat_d[i] = lat_q[i-1];
        end
        if (capture) begin
          wr_ptr_d     = wr_ptr_q + 1'b1;
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
        if (stop) begin
          overflow_d = !DUT_RDY;
          lat_d      = '0;
        end
      end
      READOUT: begin
        if (handshake) rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      period_q      <= '0;
      cnt_q         <= '0;
      data_q        <= '0;
      head_q        <= '0;
      lat_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sample_cnt_q  <= '0;
      overflow_q    <= 1'b0;
      bypass_q      <= 1'b0;
      bypass_data_q <= '0;
    end else begin
      period_q      <= period_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      head_q        <= head_d;
      lat_q         <= lat_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sample_cnt_q  <= sample_cnt_d;
      overflow_q    <= overflow_d;
      bypass_q      <= bypass_d;
      bypass_data_q <= bypass_data_d;
    end
  end

endmodule

// File: tb/tb_skeleton_capture_ctrl.sv
// Scoreboard bench: a behavioural skeleton answers triggers with 0xA000+k and
// a monitor checks every readout word against the queued expectation.
module tb_skeleton_capture_ctrl;

  localparam int W  = 16;
  localparam int H  = 26;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          RSTN;
  logic          START;
  logic [15:0]   CFG_PERIOD;
  logic [W-1:0]  CFG_DATA;
  logic          DUT_EN, DUT_TRGG;
  logic [W-1:0]  DUT_DATA_IN;
  logic [W-1:0]  dout;
  logic [H-1:0]  DUT_HEAD;
  logic          rdy;
  logic          RD_VALID;
  logic          RD_READY;
  logic [W-1:0]  RD_DATA;
  logic          RD_LAST;
  logic [H-1:0]  HEAD_OUT;
  logic          BUSY, OVERFLOW;
  logic [AW:0]   SAMPLE_CNT;

  skeleton_capture_ctrl #(
    .BITWIDTH_SYS (W),
    .BITWIDTH_HEAD(H),
    .DEPTH        (64),
    .CAPT_LAT     (1)
  ) dut (
    .CLK_SYS     (clk),
    .RSTN        (RSTN),
    .START       (START),
    .CFG_PERIOD  (CFG_PERIOD),
    .CFG_DATA    (CFG_DATA),
    .DUT_EN      (DUT_EN),
    .DUT_TRGG    (DUT_TRGG),
    .DUT_DATA_IN (DUT_DATA_IN),
    .DUT_DATA_OUT(dout),
    .DUT_HEAD    (DUT_HEAD),
    .DUT_RDY     (rdy),
    .RD_VALID    (RD_VALID),
    .RD_READY    (RD_READY),
    .RD_DATA     (RD_DATA),
    .RD_LAST     (RD_LAST),
    .HEAD_OUT    (HEAD_OUT),
    .BUSY        (BUSY),
    .OVERFLOW    (OVERFLOW),
    .SAMPLE_CNT  (SAMPLE_CNT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   trig_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_at = 0;
  bit   bp = 1'b0;
  int   trig_n = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Skeleton model: sample k appears one cycle after trigger k; RDY flags sample rdy_at.
  always @(posedge clk) begin
    if (!DUT_EN) begin
      trig_n <= 0;
      dout   <= '0;
      rdy    <= 1'b0;
    end else if (DUT_TRGG) begin
      dout   <= 16'hA000 + 16'(trig_n);
      rdy    <= (rdy_at != 0) && (trig_n + 1 == rdy_at);
      trig_n <= trig_n + 1;
    end else begin
      rdy <= 1'b0;
    end
  end

  initial begin
    RD_READY = 1'b1;
    forever begin
      @(posedge clk);
      #1 RD_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (DUT_TRGG) trig_q.push_back(cyc);
  end

  // Monitor: stability while stalled, and in-order data on each handshake.
  bit           stall_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  always @(negedge clk) begin
    exp_t e;
    if (stall_prev) begin
      checks++;
      if (!(RD_VALID && RD_DATA == prev_data && RD_LAST == prev_last)) begin
        errors++;
        $display("FAIL stall_hold: got valid=%0b data=0x%0h last=%0b expected valid=1 data=0x%0h last=%0b",
                 RD_VALID, RD_DATA, RD_LAST, prev_data, prev_last);
      end
    end
    if (RD_VALID && RD_READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", RD_DATA);
      end else begin
        e = exp_q.pop_front();
        if (RD_DATA !== e.d || RD_LAST !== e.last) begin
          errors++;
          $display("FAIL readout: got data=0x%0h last=%0b expected data=0x%0h last=%0b",
                   RD_DATA, RD_LAST, e.d, e.last);
        end else begin
          $display("readout word 0x%0h last=%0b", RD_DATA, RD_LAST);
        end
      end
    end
    stall_prev = RD_VALID && !RD_READY && RSTN;
    prev_data  = RD_DATA;
    prev_last  = RD_LAST;
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"},     int'(DUT_EN), 0);
    check({tag, "_trgg"},   int'(DUT_TRGG), 0);
    check({tag, "_din"},    int'(DUT_DATA_IN), 0);
    check({tag, "_valid"},  int'(RD_VALID), 0);
    check({tag, "_rdata"},  int'(RD_DATA), 0);
    check({tag, "_last"},   int'(RD_LAST), 0);
    check({tag, "_busy"},   int'(BUSY), 0);
    check({tag, "_head"},   int'(HEAD_OUT), 0);
    check({tag, "_ovf"},    int'(OVERFLOW), 0);
    check({tag, "_cnt"},    int'(SAMPLE_CNT), 0);
  endtask

  task automatic do_run(input string name, input int period, input int rdyat,
                        input int nexp, input bit ovf, input bit use_bp, input bit poke);
    int       peff;
    int       start_cyc;
    bit       done;
    bit       poked;
    logic [H-1:0] head;
    peff       = (period == 0) ? 1 : period;
    head       = H'($urandom);
    rdy_at     = rdyat;
    bp         = use_bp;
    CFG_PERIOD = 16'(period);
    CFG_DATA   = 16'h5A00 + 16'(period);
    DUT_HEAD   = head;
    for (int i = 0; i < nexp; i++) exp_q.push_back({16'hA000 + 16'(i), (i == nexp - 1)});
    trig_q.delete();
    @(negedge clk);
    START = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    START = 1'b0;
    done  = 1'b0;
    poked = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      START = 1'b0;
      if (i == 1) begin
        check({name, "_run_en"}, int'(DUT_EN), 1);
        check({name, "_run_din"}, int'(DUT_DATA_IN), int'(CFG_DATA));
      end
      if (i == 4) DUT_HEAD = ~head;
      if (poke && i == 3) START = 1'b1;
      if (poke && RD_VALID && !poked) begin
        START = 1'b1;
        poked = 1'b1;
      end
      if (!BUSY) done = 1'b1;
    end
    START = 1'b0;
    check({name, "_finished"}, int'(done), 1);
    check({name, "_sample_cnt"}, int'(SAMPLE_CNT), nexp);
    check({name, "_overflow"}, int'(OVERFLOW), int'(ovf));
    check({name, "_head"}, int'(HEAD_OUT), int'(head));
    check({name, "_words_left"}, exp_q.size(), 0);
    check({name, "_idle_valid"}, int'(RD_VALID), 0);
    if (trig_q.size() >= 3) begin
      check({name, "_first_trig"}, trig_q[0] - start_cyc, 2);
      check({name, "_spacing1"}, trig_q[1] - trig_q[0], peff);
      check({name, "_spacing2"}, trig_q[2] - trig_q[1], peff);
    end else begin
      check({name, "_trig_count"}, trig_q.size(), 3);
    end
    $display("run %s: sample_cnt=%0d overflow=%0b", name, SAMPLE_CNT, OVERFLOW);
    exp_q.delete();
    bp = 1'b0;
  endtask

  initial begin
    RSTN       = 1'b0;
    START      = 1'b0;
    CFG_PERIOD = '0;
    CFG_DATA   = '0;
    DUT_HEAD   = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    RSTN = 1'b1;

    // Abort a run with reset and confirm everything returns to zero.
    rdy_at     = 0;
    CFG_PERIOD = 16'd3;
    CFG_DATA   = 16'h1234;
    DUT_HEAD   = 26'h2ABCDEF;
    @(negedge clk);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    repeat (20) @(negedge clk);
    check("midrun_busy", int'(BUSY), 1);
    RSTN = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrun_reset");
    RSTN = 1'b1;
    @(negedge clk);

    do_run("p4_rdy10",    4, 10, 10, 1'b0, 1'b0, 1'b0);
    do_run("p1_full",     1, 0,  64, 1'b1, 1'b0, 1'b0);
    do_run("p2_rdy64",    2, 64, 64, 1'b0, 1'b0, 1'b0);
    do_run("p0_poke",     0, 6,  6,  1'b0, 1'b0, 1'b1);
    do_run("p2_backpres", 2, 10, 10, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
